// File: rtl/vgaram_pkg.sv
// Shared constants and FSM state type for the VGA RAM arbiter.
// Used by the arbiter top and its write buffer.
package vgaram_pkg;

  localparam int DATA_W          = 8;
  localparam int RAM_ADDR_W      = 16;
  localparam int WFIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_RD_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO used as the host write buffer.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == LVL_W'(0));
  assign level   = count;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vgaram_arbiter.sv
// Single-port video RAM arbiter: display fetcher has absolute priority,
// host writes are buffered and host reads wait until the buffer drains.
module vgaram_arbiter
  import vgaram_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [ADDR_W-1:0]            i_vga_addr,
  input  logic                         i_vga_access,
  output logic [DATA_W-1:0]            o_vga_dat,
  input  logic [ADDR_W-1:0]            i_host_addr,
  input  logic [DATA_W-1:0]            i_host_dat,
  input  logic                         i_host_we,
  input  logic                         i_host_cs,
  output logic                         o_host_ack,
  output logic [DATA_W-1:0]            o_host_dat,
  output logic [ADDR_W-1:0]            o_ram_addr,
  output logic [DATA_W-1:0]            o_ram_dat,
  output logic                         o_ram_we,
  output logic                         o_ram_cs,
  input  logic [DATA_W-1:0]            i_ram_dat,
  output logic [$clog2(WFIFO_DEPTH):0] o_wfifo_level,
  output logic                         o_busy
);

  localparam int ENT_W = ADDR_W + DATA_W;

  arb_state_e        state_r;
  arb_state_e        state_nxt;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] host_dat_r;
  logic              ack_r;
  logic              slot;
  logic              idle_req;
  logic              rd_accept;
  logic              wr_accept;
  logic              rd_issue;
  logic              drain;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  // A pending read waits for an empty buffer, which gives read-after-write ordering.
  assign slot      = !i_vga_access;
  assign idle_req  = (state_r == ST_IDLE) && i_host_cs && !ack_r && !i_reset;
  assign drain     = slot && !fifo_empty && !i_reset;
  assign rd_issue  = slot && (state_r == ST_RD_PEND) && fifo_empty && !i_reset;
  assign rd_accept = idle_req && !i_host_we;
  assign wr_accept = idle_req && i_host_we && (!fifo_full || drain);

  sync_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(WFIFO_DEPTH)
  ) u_wfifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .push   (wr_accept),
    .pop    (drain),
    .din    ({i_host_addr, i_host_dat}),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (o_wfifo_level)
  );

  // Host read FSM next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_accept) begin
          state_nxt = ST_RD_PEND;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_PEND: begin
        if (rd_issue) begin
          state_nxt = ST_RD_DATA;
        end else begin
          state_nxt = ST_RD_PEND;
        end
      end
      ST_RD_DATA: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Host read FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Host handshake registers: ack pulse, latched read address, held read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_r      <= 1'b0;
      rd_addr_r  <= '0;
      host_dat_r <= '0;
    end else begin
      ack_r <= wr_accept || rd_issue;
      if (rd_accept) begin
        rd_addr_r <= i_host_addr;
      end
      if (state_r == ST_RD_DATA) begin
        host_dat_r <= i_ram_dat;
      end
    end
  end

  // RAM port mux: fetcher, then pending read, then buffered write.
  always_comb begin
    o_ram_addr = '0;
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    if (i_vga_access) begin
      o_ram_addr = i_vga_addr;
      o_ram_cs   = 1'b1;
    end else if (rd_issue) begin
      o_ram_addr = rd_addr_r;
      o_ram_cs   = 1'b1;
    end else if (drain) begin
      o_ram_addr = fifo_head[ENT_W-1:DATA_W];
      o_ram_cs   = 1'b1;
      o_ram_we   = 1'b1;
    end else begin
      o_ram_cs   = 1'b0;
    end
  end

  // Read data is forwarded during the ack cycle and held from the register after.
  assign o_ram_dat  = fifo_head[DATA_W-1:0];
  assign o_vga_dat  = i_ram_dat;
  assign o_host_ack = ack_r;
  assign o_host_dat = (state_r == ST_RD_DATA) ? i_ram_dat : host_dat_r;
  assign o_busy     = (state_r != ST_IDLE) || !fifo_empty;

endmodule
